// File: rtl/lsu_pkg.sv
// Shared funct3 encodings and FSM state type for the MEM-stage load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables / replicated data, load extraction and legality checks.
// Purely combinational, zero latency, no flow control.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        we,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misalign,
    output logic        illegal
);

    logic [31:0] shifted;

    always_comb begin
        be        = 4'hF;
        wdata_rep = wdata;
        misalign  = 1'b0;
        illegal   = 1'b0;
        case (funct3)
            F3_B: begin
                if (we) begin
                    be        = 4'b0001 << off;
                    wdata_rep = {4{wdata[7:0]}};
                end
            end
            F3_H: begin
                misalign = off[0];
                if (we) begin
                    be        = 4'b0011 << off;
                    wdata_rep = {2{wdata[15:0]}};
                end
            end
            F3_W:    misalign = |off;
            F3_BU:   illegal  = we;
            F3_HU: begin
                misalign = off[0];
                illegal  = we;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign shifted = rdata >> {off, 3'b000};

    always_comb begin
        rdata_ext = shifted;
        case (funct3)
            F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   rdata_ext = {24'h0, shifted[7:0]};
            F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   rdata_ext = {16'h0, shifted[15:0]};
            default: rdata_ext = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: req/gnt/rvalid handshake with data memory, stalls the pipe while busy.
// Minimum latency: load 3 stall cycles (resp_valid in 4th), store 2; mem_* held stable until mem_gnt.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic              fault,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    generate
        if (DATA_W != 32) begin : g_bad_data_w
            $error("load_store_unit: DATA_W must be 32 for RV32");
        end
    endgenerate

    lsu_state_t  state, state_nxt;
    logic [2:0]  op_funct3;
    logic [1:0]  op_off;

    logic [2:0]  sel_funct3;
    logic        sel_we;
    logic [1:0]  sel_off;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [31:0] rdata_ext;
    logic        misalign;
    logic        illegal;
    logic        bad_op;
    logic        accept;
    logic        capture;

    // In IDLE the aligner looks at the incoming op; afterwards at the latched one for load extraction.
    assign sel_funct3 = (state == IDLE) ? req_funct3    : op_funct3;
    assign sel_we     = (state == IDLE) ? req_we        : mem_we;
    assign sel_off    = (state == IDLE) ? req_addr[1:0] : op_off;

    lsu_lane_align u_align (
        .funct3    (sel_funct3),
        .we        (sel_we),
        .off       (sel_off),
        .wdata     (req_wdata),
        .rdata     (mem_rdata),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext),
        .misalign  (misalign),
        .illegal   (illegal)
    );

    assign bad_op  = illegal | misalign;
    assign accept  = rst_n & (state == IDLE) & req_valid & ~bad_op;
    assign fault   = rst_n & (state == IDLE) & req_valid & bad_op;
    assign capture = ~mem_we & mem_rvalid &
                     (((state == REQ) & mem_gnt) | (state == WAIT));

    assign stall      = accept | (state == REQ) | (state == WAIT);
    assign mem_req    = (state == REQ);
    assign resp_valid = (state == DONE) & ~mem_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = REQ;
            REQ: begin
                if (mem_gnt) begin
                    state_nxt = (mem_we || mem_rvalid) ? DONE : WAIT;
                end
            end
            WAIT: if (mem_rvalid) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_funct3  <= 3'b000;
            op_off     <= 2'b00;
            mem_we     <= 1'b0;
            mem_be     <= 4'h0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_rdata <= '0;
        end else begin
            if (accept) begin
                op_funct3 <= req_funct3;
                op_off    <= req_addr[1:0];
                mem_we    <= req_we;
                mem_be    <= be;
                mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                mem_wdata <= wdata_rep;
            end
            if (capture) begin
                resp_rdata <= rdata_ext;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed loads/stores, faults, gnt stalls and reset aborts.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        stall, fault, resp_valid;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_load = 32'h0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .fault      (fault),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor: every resp_valid pulse must match the oldest outstanding load.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (resp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: resp_valid=1 data 0x%08h with no load outstanding", resp_rdata);
                end else begin
                    check("resp_rdata", resp_rdata, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_op(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                          input int gnt_wait, input bit same, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_resp);
        int          stalls = 0;
        int          req_cnt = 0;
        int          exp_stalls;
        bit          done = 1'b0;
        bit          rv_pend = 1'b0;
        logic [31:0] exp_addr;
        exp_stalls = 1 + (gnt_wait + 1) + ((!we && !same) ? 1 : 0);
        exp_addr   = {addr[31:2], 2'b00};
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        mem_rdata  = rdata;
        if (!we) begin
            exp_q.push_back(exp_resp);
            last_load = exp_resp;
        end
        for (int g = 0; g < 40 && !done; g++) begin
            if (g > 0) @(negedge clk);
            #1;
            mem_gnt    = 1'b0;
            mem_rvalid = rv_pend;
            rv_pend    = 1'b0;
            if (stall) stalls++;
            else done = 1'b1;
            if (mem_req) begin
                check({name, "_be"}, {28'h0, mem_be}, {28'h0, exp_be});
                check({name, "_addr"}, mem_addr, exp_addr);
                check({name, "_we"}, {31'h0, mem_we}, {31'h0, we});
                if (we) check({name, "_wdata"}, mem_wdata, exp_wd);
                if (req_cnt == gnt_wait) begin
                    mem_gnt = 1'b1;
                    if (!we) begin
                        if (same) mem_rvalid = 1'b1;
                        else rv_pend = 1'b1;
                    end
                end
                req_cnt++;
            end
        end
        check({name, "_done"}, {31'h0, done}, 32'd1);
        check({name, "_stalls"}, stalls, exp_stalls);
        req_valid = 1'b0;
        if (we) begin
            @(negedge clk);
            #1;
            check({name, "_rdata_kept"}, resp_rdata, last_load);
        end
    endtask

    task automatic run_fault(input string name, input logic we, input logic [2:0] f3, input logic [31:0] addr);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        #1;
        check({name, "_fault"}, {31'h0, fault}, 32'd1);
        check({name, "_stall"}, {31'h0, stall}, 32'd0);
        @(negedge clk);
        #1;
        check({name, "_no_req"}, {31'h0, mem_req}, 32'd0);
        req_valid = 1'b0;
        #1;
        check({name, "_fault_off"}, {31'h0, fault}, 32'd0);
    endtask

    initial begin
        #1;
        check("rst_ctrl", {23'h0, stall, fault, resp_valid, mem_req, mem_we, mem_be}, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        //     name    we    f3     addr          wdata         rdata         gw same be       wdata         resp
        run_op("lw",   1'b0, F3_W,  32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 4'hF,    32'h0,        32'hDEADBEEF);
        run_op("lb",   1'b0, F3_B,  32'h103, 32'h0,        32'h80FF1234, 0, 0, 4'hF,    32'h0,        32'hFFFFFF80);
        run_op("lbu",  1'b0, F3_BU, 32'h103, 32'h0,        32'h80FF1234, 0, 0, 4'hF,    32'h0,        32'h00000080);
        run_op("lh",   1'b0, F3_H,  32'h102, 32'h0,        32'h80FF1234, 0, 0, 4'hF,    32'h0,        32'hFFFF80FF);
        run_op("lhu",  1'b0, F3_HU, 32'h100, 32'h0,        32'h80FF1234, 0, 0, 4'hF,    32'h0,        32'h00001234);
        run_op("lb1",  1'b0, F3_B,  32'h101, 32'h0,        32'h80FF1234, 0, 0, 4'hF,    32'h0,        32'h00000012);
        run_op("sb",   1'b1, F3_B,  32'h201, 32'h000000A5, 32'h0,        0, 0, 4'b0010, 32'hA5A5A5A5, 32'h0);
        run_op("sh",   1'b1, F3_H,  32'h202, 32'h0000BEEF, 32'h0,        0, 0, 4'b1100, 32'hBEEFBEEF, 32'h0);
        run_op("sw",   1'b1, F3_W,  32'h204, 32'h12345678, 32'h0,        0, 0, 4'hF,    32'h12345678, 32'h0);
        run_op("lwgw", 1'b0, F3_W,  32'h300, 32'h0,        32'h0BADF00D, 5, 0, 4'hF,    32'h0,        32'h0BADF00D);
        run_op("swgw", 1'b1, F3_W,  32'h308, 32'hCAFEF00D, 32'h0,        3, 0, 4'hF,    32'hCAFEF00D, 32'h0);
        run_op("same", 1'b0, F3_HU, 32'h302, 32'h0,        32'hCAFE0000, 0, 1, 4'hF,    32'h0,        32'h0000CAFE);

        run_fault("f_lw_mis", 1'b0, F3_W,   32'h102);
        run_fault("f_lh_mis", 1'b0, F3_H,   32'h101);
        run_fault("f_f3_011", 1'b0, 3'b011, 32'h100);
        run_fault("f_sbu",    1'b1, F3_BU,  32'h100);

        // Reset while the request is still waiting for gnt: mem_req must drop at once.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h400; mem_rdata = 32'h11111111;
        @(negedge clk);
        #1;
        check("rstreq_req_before", {31'h0, mem_req}, 32'd1);
        rst_n = 1'b0; req_valid = 1'b0;
        #1;
        check("rstreq_req_after", {31'h0, mem_req}, 32'd0);
        check("rstreq_stall_after", {31'h0, stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in WAIT, then a stale rvalid that must be ignored.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h404; mem_rdata = 32'h22222222;
        @(negedge clk);
        #1;
        mem_gnt = 1'b1;
        @(negedge clk);
        #1;
        mem_gnt = 1'b0;
        check("rstwait_stall_before", {31'h0, stall}, 32'd1);
        check("rstwait_req_before", {31'h0, mem_req}, 32'd0);
        rst_n = 1'b0; req_valid = 1'b0;
        #1;
        check("rstwait_stall_after", {31'h0, stall}, 32'd0);
        check("rstwait_req_after", {31'h0, mem_req}, 32'd0);
        check("rstwait_be", {28'h0, mem_be}, 32'h0);
        check("rstwait_addr", mem_addr, 32'h0);
        check("rstwait_rdata", resp_rdata, 32'h0);
        last_load = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check("stale_stall", {31'h0, stall}, 32'd0);
        check("stale_rdata", resp_rdata, 32'h0);

        run_op("b2b_lw",  1'b0, F3_W,  32'h500, 32'h0, 32'hA5A55A5A, 0, 0, 4'hF, 32'h0, 32'hA5A55A5A);
        run_op("b2b_lbu", 1'b0, F3_BU, 32'h502, 32'h0, 32'h00FE0000, 0, 0, 4'hF, 32'h0, 32'h000000FE);

        @(negedge clk);
        @(negedge clk);
        #2;
        check("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage memory access unit of the RV32I pipeline.
- Takes a load or store from the EX/MEM register and runs a req/gnt/rvalid handshake with the data memory.
- Stalls the pipeline while an access is in flight.
- Returns lane-aligned, sign- or zero-extended load data as the memory input of the writeback result mux2.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width; fixed at 32 for RV32. Other values are unsupported and must be rejected by an elaboration assertion.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  memory instruction present in MEM stage
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  LB=000 LH=001 LW=010 LBU=100 LHU=101; stores use SB=000 SH=001 SW=010
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data (rs2)
- stall  out  1  freeze IF/ID/EX/MEM registers
- fault  out  1  one-cycle pulse: misaligned address or illegal funct3
- resp_valid  out  1  one-cycle pulse: resp_rdata updated by a load
- resp_rdata  out  DATA_W  extended load data to writeback mux
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_be  out  4  byte enables
- mem_addr  out  ADDR_W  word-aligned address ({req_addr[ADDR_W-1:2],2'b00})
- mem_wdata  out  DATA_W  lane-replicated store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_W  read word

Behaviour:
- Single clock.
- Reset is asynchronous, active-low (rst_n). On assertion, state = IDLE; all outputs 0; latched op fields 0.
- Reset mid-access: mem_req drops immediately. mem_rvalid arriving in IDLE is ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, req_valid=1, legal op:
  - Latch we, funct3, addr[1:0], mem_addr, mem_be, mem_wdata.
  - Go to REQ. stall=1 combinationally in this cycle.
- IDLE, req_valid=1, illegal op:
  - fault=1 for that cycle; no memory access; stall=0; stay IDLE.
  - Illegal means any of: funct3 in {011,110,111}; load with funct3 in {100,101} used as store (req_we=1); halfword with addr[0]=1; word with addr[1:0]!=0.
- REQ:
  - mem_req=1; mem_we/mem_be/mem_addr/mem_wdata held stable until mem_gnt.
  - On gnt with store: go to DONE.
  - On gnt with load and mem_rvalid=0: go to WAIT.
  - On gnt with load and mem_rvalid=1 in the same cycle: capture data, go to DONE.
- WAIT: mem_req=0. On mem_rvalid, capture extracted data into resp_rdata and go to DONE.
- DONE:
  - stall=0; resp_valid=1 if load.
  - Unconditionally return to IDLE. req_valid is ignored because it still shows the completed instruction, which advances at this edge.
- stall = (IDLE & req_valid & legal) | REQ | WAIT.
- Minimum latency (gnt in first REQ cycle, rvalid next cycle):
  - Load: 3 stall cycles; resp_valid in the 4th cycle.
  - Store with immediate gnt: 2 stall cycles.
- Byte enables, off = addr[1:0]:
  - SB: 4'b0001<<off, wdata {4{wdata[7:0]}}.
  - SH: 4'b0011<<off, wdata {2{wdata[15:0]}}.
  - SW: 4'hF.
  - Loads: mem_be = 4'hF.
- Load extraction: shifted = mem_rdata >> (8*off).
  - LB: sign-extend shifted[7:0].
  - LBU: zero-extend shifted[7:0].
  - LH: sign-extend shifted[15:0].
  - LHU: zero-extend shifted[15:0].
  - LW: whole word.
- resp_rdata holds its value between loads; stores do not change it.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - lsu_state_t enum: IDLE, REQ, WAIT, DONE.
- One combinational sub-module, lsu_lane_align. It takes funct3 and offset and produces mem_be, replicated wdata, extended rdata, and the misalign flag.
- FSM and registers live in load_store_unit.

Test Plan:
- LW, addr 0x100, mem_rdata 0xDEADBEEF, gnt immediate, rvalid +1 -> mem_be=F, mem_addr=0x100, stall 3 cycles, resp_valid pulse, resp_rdata=0xDEADBEEF.
- LB addr 0x103 / LBU addr 0x103, rdata 0x80FF1234 -> 0xFFFFFF80 / 0x00000080. LH addr 0x102 -> 0xFFFF80FF.
- SB addr 0x201, wdata 0x000000A5 -> mem_be=0010, mem_wdata=0xA5A5A5A5, mem_we=1. SH addr 0x202 -> mem_be=1100. resp_valid stays 0; resp_rdata unchanged.
- mem_gnt held low 5 cycles -> mem_req and all mem_* outputs stable, stall=1 throughout. Gnt and rvalid in the same cycle -> DONE next cycle with correct data.
- LW addr 0x102, LH addr 0x101, funct3=011 -> fault pulse, no mem_req, stall=0.
- rst_n low in WAIT -> mem_req/stall 0 immediately. Stale mem_rvalid after release is ignored; resp_valid stays 0. Back-to-back loads after reset each complete once.
